io_debounce: RTL and testbench



---
 rtl/io_debounce.sv | 143 ++++++++++++++
 tb/tb_io_debounce.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_debounce.sv
// io_debounce -- pad input conditioner in front of the binary counter core.
//
// Each of NCH raw pad levels is synchronised to wb_clk_i with two flops. It is
// then sampled once per prescaled tick. A new level is accepted only after
// STABLE consecutive tick samples disagree with the current level. The
// accepted level is registered, and a one-cycle rise/fall pulse is raised on
// the cycle the new level first appears.
//
// Optional feature (macro IO_DEBOUNCE_GLITCH_CNT_EN): adds a saturating 8-bit
// glitch counter per channel. A glitch is an aborted count. The counters are
// cleared by glitch_clr_i or by reset.
//
// Ports:
//   wb_clk_i      in   1        single clock
//   wb_rst_i      in   1        synchronous, active-high reset
//   en_i          in   1        debounce enable; 0 freezes sampling
//   pad_i         in   NCH      raw asynchronous pad levels
//   glitch_clr_i  in   1        (macro only) clear all glitch counters
//   glitch_cnt_o  out  NCH*8    (macro only) channel i in [8i+7:8i]
//   level_o       out  NCH      debounced level
//   rise_o        out  NCH      one-cycle pulse on level_o 0->1
//   fall_o        out  NCH      one-cycle pulse on level_o 1->0
//   tick_o        out  1        sample tick (debug/test)

module io_debounce #(
  parameter int NCH       = 4,
  parameter int PRESCALE  = 256,
  parameter int STABLE    = 4,
  parameter int RST_LEVEL = 0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             en_i,
  input  logic [NCH-1:0]   pad_i,
`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
  input  logic             glitch_clr_i,
  output logic [NCH*8-1:0] glitch_cnt_o,
`endif
  output logic [NCH-1:0]   level_o,
  output logic [NCH-1:0]   rise_o,
  output logic [NCH-1:0]   fall_o,
  output logic             tick_o
);

  // PRESCALE=1 still needs a 1-bit counter that simply stays at 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(STABLE);

  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0]  C_LAST  = CW'(STABLE - 1);
  localparam logic [NCH-1:0] RST_VEC = {NCH{RST_LEVEL != 0}};

  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [PW-1:0]  ps_cnt;
  logic           tick;
  logic [CW-1:0]  stab_cnt [NCH];

  // Synchroniser runs regardless of en_i.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1 <= RST_VEC;
      sync2 <= RST_VEC;
    end else begin
      sync1 <= pad_i;
      sync2 <= sync1;
    end
  end

  // Prescaler. Holding it at 0 while disabled makes the first tick after
  // re-enable land a full prescale period later.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !en_i) begin
      ps_cnt <= '0;
    end else if (ps_cnt == PS_LAST) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PW'(1);
    end
  end

  assign tick   = en_i && !wb_rst_i && (ps_cnt == PS_LAST);
  assign tick_o = tick;

  // Per-channel stability counters and the debounced level. A tick sample
  // that agrees with level_o discards any partial count.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      level_o <= RST_VEC;
      rise_o  <= '0;
      fall_o  <= '0;
      for (int i = 0; i < NCH; i++) begin
        stab_cnt[i] <= '0;
      end
    end else begin
      rise_o <= '0;
      fall_o <= '0;
      if (tick) begin
        for (int i = 0; i < NCH; i++) begin
          if (sync2[i] == level_o[i]) begin
            stab_cnt[i] <= '0;
          end else if (stab_cnt[i] == C_LAST) begin
            level_o[i]  <= sync2[i];
            stab_cnt[i] <= '0;
            rise_o[i]   <= sync2[i];
            fall_o[i]   <= ~sync2[i];
          end else begin
            stab_cnt[i] <= stab_cnt[i] + CW'(1);
          end
        end
      end
    end
  end

`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt [NCH];

  // A glitch is a tick that resets a non-zero stability count.
  // The clear input takes priority over an increment in the same cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || glitch_clr_i) begin
      for (int i = 0; i < NCH; i++) begin
        glitch_cnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < NCH; i++) begin
        if ((sync2[i] == level_o[i]) && (stab_cnt[i] != '0) &&
            (glitch_cnt[i] != 8'hFF)) begin
          glitch_cnt[i] <= glitch_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    glitch_cnt_o = '0;
    for (int i = 0; i < NCH; i++) begin
      glitch_cnt_o[8*i +: 8] = glitch_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_io_debounce.sv
// Bench for io_debounce with NCH=4, PRESCALE=4, STABLE=3, RST_LEVEL=0.
//
// The reference model keeps a sliding window of the last tick samples on
// each channel. A channel's level flips when the newest STABLE samples taken
// since the last reset all differ from the current level. Directed sequences
// add hand-computed literal checks on latency, pulse counts and tick timing.

module tb_io_debounce;
  localparam int NCH = 4;
  localparam int P   = 4;
  localparam int S   = 3;
  localparam int RL  = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] pad = 4'hF;
  logic [3:0] level, rise, fall;
  logic       tick;
`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
  logic        gclr = 1'b0;
  logic [31:0] gcnt;
`endif

  io_debounce #(.NCH(NCH), .PRESCALE(P), .STABLE(S), .RST_LEVEL(RL)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .en_i         (en),
    .pad_i        (pad),
`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
    .glitch_clr_i (gclr),
    .glitch_cnt_o (gcnt),
`endif
    .level_o      (level),
    .rise_o       (rise),
    .fall_o       (fall),
    .tick_o       (tick)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0]  m_s1, m_s2, m_level, m_rise, m_fall;
  int          m_phase = 0;
  logic [15:0] m_win [4];
  int          m_nsamp [4];
  int          m_g [4];
  logic [3:0]  mdl_s;
  bit          mdl_tk, prev_diff, all_diff;

  always @(posedge clk) begin
    mdl_s  = m_s2;
    mdl_tk = en && !rst && (m_phase == P - 1);
    m_rise = '0;
    m_fall = '0;
    if (rst) begin
      m_s1    = '0;
      m_s2    = '0;
      m_level = '0;
      m_phase = 0;
      for (int i = 0; i < 4; i++) begin
        m_win[i]   = '0;
        m_nsamp[i] = 0;
        m_g[i]     = 0;
      end
    end else begin
      m_s2    = m_s1;
      m_s1    = pad;
      m_phase = en ? (m_phase + 1) % P : 0;
      if (mdl_tk) begin
        for (int i = 0; i < 4; i++) begin
          prev_diff = (m_nsamp[i] > 0) && (m_win[i][0] != m_level[i]);
          if ((mdl_s[i] == m_level[i]) && prev_diff && (m_g[i] < 255)) m_g[i]++;
          m_win[i] = {m_win[i][14:0], mdl_s[i]};
          if (m_nsamp[i] < 16) m_nsamp[i]++;
          all_diff = (m_nsamp[i] >= S);
          for (int k = 0; k < S; k++) begin
            if (m_win[i][k] == m_level[i]) all_diff = 1'b0;
          end
          if (all_diff) begin
            m_level[i] = mdl_s[i];
            if (mdl_s[i]) m_rise[i] = 1'b1;
            else          m_fall[i] = 1'b1;
          end
        end
      end
`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
      if (gclr) begin
        for (int i = 0; i < 4; i++) m_g[i] = 0;
      end
`endif
    end
  end

`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
  function automatic logic [31:0] m_gvec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = 8'(m_g[i]);
    return v;
  endfunction
`endif

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("level", 32'(level), 32'(m_level));
      chk("rise", 32'(rise), 32'(m_rise));
      chk("fall", 32'(fall), 32'(m_fall));
      chk("tick", 32'(tick), 32'(en && !rst && (m_phase == P - 1)));
      chk("rise_and_fall", 32'(rise & fall), 32'd0);
`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
      chk("glitch_cnt", gcnt, m_gvec());
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  int acc_r [4];
  int acc_f [4];
  int acc_t;
  int acc_sim;

  task automatic clr_acc();
    for (int i = 0; i < 4; i++) begin
      acc_r[i] = 0;
      acc_f[i] = 0;
    end
    acc_t   = 0;
    acc_sim = 0;
  endtask

  task automatic step(input logic [3:0] p, input logic e, input logic r);
    @(negedge clk);
    pad = p;
    en  = e;
    rst = r;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) acc_r[i]++;
      if (fall[i]) acc_f[i]++;
    end
    if (tick) acc_t++;
    if ((rise & fall) != 4'h0) acc_sim++;
  endtask

  logic [7:0]  tseq;
  int          lat, rk;
  logic [3:0]  pm;

  initial begin
    clr_acc();

    // Reset with all pads high: outputs must stay at the reset level.
    repeat (3) step(4'hF, 1'b1, 1'b1);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_rise", 32'(rise), 32'd0);
    chk("reset_fall", 32'(fall), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
    chk("reset_glitch_cnt", gcnt, 32'd0);
`endif

    // Tick is visible after edges 3 and 7 following release (cycles 4 and 8).
    for (int k = 0; k < 8; k++) begin
      step(4'h0, 1'b1, 1'b0);
      tseq[k] = tick;
    end
    chk("tick_sequence", 32'(tseq), 32'h44);

    // Clean rise on channel 0.
    clr_acc();
    lat = 0;
    rk  = 0;
    for (int k = 1; k <= 40; k++) begin
      step(4'b0001, 1'b1, 1'b0);
      if (level[0] && lat == 0) lat = k;
      if (rise[0]) rk = k;
    end
    chk("rise_latency_in_range", 32'(lat >= 11 && lat <= 14), 32'd1);
    chk("rise_pulse_count", 32'(acc_r[0]), 32'd1);
    chk("rise_coincident", 32'(rk), 32'(lat));
    chk("rise_no_fall", 32'(acc_f[0]), 32'd0);

    // Glitch on channel 1: two agreeing ticks, then back low.
    clr_acc();
    repeat (8)  step(4'b0011, 1'b1, 1'b0);
    repeat (20) step(4'b0001, 1'b1, 1'b0);
    chk("glitch_level", 32'(level[1]), 32'd0);
    chk("glitch_no_rise", 32'(acc_r[1]), 32'd0);
    chk("glitch_no_fall", 32'(acc_f[1]), 32'd0);
`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_cnt_one", 32'(gcnt[15:8]), 32'd1);
    for (int g = 0; g < 299; g++) begin
      repeat (8) step(4'b0011, 1'b1, 1'b0);
      repeat (8) step(4'b0001, 1'b1, 1'b0);
    end
    chk("glitch_cnt_sat", 32'(gcnt[15:8]), 32'd255);
    @(negedge clk);
    gclr = 1'b1;
    @(negedge clk);
    gclr = 1'b0;
    @(posedge clk);
    #1;
    chk("glitch_cnt_cleared", gcnt, 32'd0);
`endif

    // Enable gate.
    repeat (2) step(4'h0, 1'b1, 1'b1);
    clr_acc();
    repeat (100) step(4'hF, 1'b0, 1'b0);
    chk("gate_level", 32'(level), 32'd0);
    chk("gate_no_tick", 32'(acc_t), 32'd0);
    lat = 0;
    rk  = 0;
    for (int k = 1; k <= 30; k++) begin
      step(4'hF, 1'b1, 1'b0);
      if (level == 4'hF && lat == 0) lat = k;
      if (rise == 4'hF) rk = k;
    end
    chk("gate_latency", 32'(lat), 32'd12);
    chk("gate_rise_together", 32'(rk), 32'd12);
    chk("gate_rise_ch3_count", 32'(acc_r[3]), 32'd1);

    // Reset mid-count on channel 2: two ticks counted, then reset.
    repeat (2) step(4'h0, 1'b1, 1'b1);
    clr_acc();
    repeat (10) step(4'b0100, 1'b1, 1'b0);
    chk("midcount_level_before", 32'(level[2]), 32'd0);
    step(4'b0100, 1'b1, 1'b1);
    lat = 0;
    rk  = 0;
    for (int k = 1; k <= 30; k++) begin
      step(4'b0100, 1'b1, 1'b0);
      if (level[2] && lat == 0) lat = k;
      if (rise[2]) rk = k;
    end
    // Sync refills by edge 2; ticks then fall on edges 4, 8 and 12.
    chk("midcount_latency", 32'(lat), 32'd12);
    chk("midcount_rise_at", 32'(rk), 32'd12);
    chk("midcount_rise_count", 32'(acc_r[2]), 32'd1);

    // Fall on channel 3 while channel 0 toggles every 2 cycles.
    repeat (20) step(4'hF, 1'b1, 1'b0);
    chk("mixed_start_level", 32'(level), 32'hF);
    clr_acc();
    for (int k = 0; k < 60; k++) begin
      pm = 4'b0110;
      pm[0] = ((k / 2) % 2 == 0);
      step(pm, 1'b1, 1'b0);
    end
    chk("mixed_fall3_count", 32'(acc_f[3]), 32'd1);
    chk("mixed_rise3_count", 32'(acc_r[3]), 32'd0);
    chk("mixed_level3", 32'(level[3]), 32'd0);
    chk("mixed_no_simultaneous", 32'(acc_sim), 32'd0);

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
